// File: rtl/pipelined_alu.sv
// Two-stage valid/ready pipelined ALU: S1 registers the request, S2 registers result and flags.
// Define PIPE_ALU_SHIFT_EN to build the SLL/SRL/SRA shifter; without it those opcodes are illegal.
module pipelined_alu #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] w,
    output logic         zero,
    output logic         neg,
    output logic         carry,
    output logic         ovf,
    output logic         illegal
);
    localparam int STAGES = 2;

`ifdef PIPE_ALU_SHIFT_EN
    localparam int SHW = $clog2(N);
`endif

    typedef struct packed {
        logic [3:0]   op;
        logic [N-1:0] a;
        logic [N-1:0] b;
    } req_t;

    typedef struct packed {
        logic [N-1:0] w;
        logic         zero;
        logic         neg;
        logic         carry;
        logic         ovf;
        logic         illegal;
    } res_t;

    // Idle result presented after reset: w=0 so zero=1, all other flags clear.
    localparam res_t RES_RST = {{N{1'b0}}, 1'b1, 4'b0000};

    logic [STAGES:1] vld_pipe_q, vld_pipe_d;
    req_t            req_q, req_d;
    res_t            res_q, res_d, res_c;
    logic            adv2, accept, move;
    logic [N:0]      sum_ext, dif_ext;

    assign adv2     = !vld_pipe_q[2] || out_ready;
    assign in_ready = !vld_pipe_q[1] || adv2;
    assign accept   = in_valid && in_ready;
    assign move     = vld_pipe_q[1] && adv2;

    // Carry-out of the add, and no-borrow of the subtract as a + ~b + 1.
    assign sum_ext = {1'b0, req_q.a} + {1'b0, req_q.b};
    assign dif_ext = {1'b0, req_q.a} + {1'b0, ~req_q.b} + {{N{1'b0}}, 1'b1};

    always_comb begin
        res_c = '0;
        case (req_q.op)
            4'b0000: begin
                res_c.w     = sum_ext[N-1:0];
                res_c.carry = sum_ext[N];
                res_c.ovf   = (req_q.a[N-1] == req_q.b[N-1]) && (sum_ext[N-1] != req_q.a[N-1]);
            end
            4'b0001: begin
                res_c.w     = dif_ext[N-1:0];
                res_c.carry = dif_ext[N];
                res_c.ovf   = (req_q.a[N-1] != req_q.b[N-1]) && (dif_ext[N-1] != req_q.a[N-1]);
            end
            4'b0010: res_c.w = req_q.a & req_q.b;
            4'b0011: res_c.w = req_q.a | req_q.b;
            4'b0100: res_c.w = req_q.a ^ req_q.b;
            4'b0101: res_c.w = {{(N-1){1'b0}}, $signed(req_q.a) < $signed(req_q.b)};
            4'b0110: res_c.w = {{(N-1){1'b0}}, req_q.a < req_q.b};
`ifdef PIPE_ALU_SHIFT_EN
            4'b1000: res_c.w = req_q.a << req_q.b[SHW-1:0];
            4'b1001: res_c.w = req_q.a >> req_q.b[SHW-1:0];
            4'b1010: res_c.w = $unsigned($signed(req_q.a) >>> req_q.b[SHW-1:0]);
`endif
            default: res_c.illegal = 1'b1;
        endcase
        res_c.zero = (res_c.w == '0);
        res_c.neg  = res_c.w[N-1];
    end

    // S2 loads whenever it is free or draining; its data only changes on an S1->S2 move.
    always_comb begin
        vld_pipe_d[1] = accept || (vld_pipe_q[1] && !move);
        vld_pipe_d[2] = adv2 ? vld_pipe_q[1] : vld_pipe_q[2];
        req_d         = accept ? {op, a, b} : req_q;
        res_d         = move ? res_c : res_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe_q <= '0;
            req_q      <= '0;
            res_q      <= RES_RST;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            req_q      <= req_d;
            res_q      <= res_d;
        end
    end

    assign out_valid = vld_pipe_q[2];
    assign w         = res_q.w;
    assign zero      = res_q.zero;
    assign neg       = res_q.neg;
    assign carry     = res_q.carry;
    assign ovf       = res_q.ovf;
    assign illegal   = res_q.illegal;
endmodule

// File: tb/tb_pipelined_alu.sv
// Bench for pipelined_alu (N=32): directed vector table, stall/reset sequences and a random
// stream checked against an arithmetic reference model with an in-order scoreboard.
module tb_pipelined_alu;
    logic        clk = 1'b0, rst = 1'b1;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic [3:0]  op = 4'h0;
    logic [31:0] a = '0, b = '0, w;
    logic        zero, neg, carry, ovf, illegal;

    pipelined_alu #(.N(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .w(w), .zero(zero), .neg(neg),
        .carry(carry), .ovf(ovf), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] w; logic z, n, c, o, il; } res_t;
    typedef struct { logic [3:0] op; logic [31:0] a, b; res_t e; } vec_t;
    typedef struct { res_t e; int acc; } sb_t;

    localparam logic [36:0] RSTPK = {32'h0, 1'b1, 4'b0000};

    int          nvec = 0, nmis = 0, ecnt = 0, n_out = 0, n_acc = 0;
    sb_t         q[$];
    logic        stall_prev = 1'b0, inr_low = 1'b0;
    logic [36:0] snap;
    vec_t        tbl[15];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [36:0] pk(input res_t r);
        return {r.w, r.z, r.n, r.c, r.o, r.il};
    endfunction

    function automatic logic [36:0] dut_pk();
        return {w, zero, neg, carry, ovf, illegal};
    endfunction

    // Reference: true-integer arithmetic, then wrapped to 32 bits.
    function automatic res_t ref_alu(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        res_t r;
        longint sx, sy, s;
        longint unsigned u;
        int sh;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        sh = int'(y % 32);
        r.w = '0; r.c = 1'b0; r.o = 1'b0; r.il = 1'b0;
        case (o)
            4'd0: begin
                u = longint'(x) + longint'(y);
                r.w = u[31:0]; r.c = (u > 64'hFFFF_FFFF);
                s = sx + sy; r.o = (s != longint'($signed(r.w)));
            end
            4'd1: begin
                r.w = x - y; r.c = (x >= y);
                s = sx - sy; r.o = (s != longint'($signed(r.w)));
            end
            4'd2: r.w = x & y;
            4'd3: r.w = x | y;
            4'd4: r.w = x ^ y;
            4'd5: r.w = (sx < sy) ? 32'd1 : 32'd0;
            4'd6: r.w = (x < y) ? 32'd1 : 32'd0;
`ifdef PIPE_ALU_SHIFT_EN
            4'd8:  r.w = x << sh;
            4'd9:  r.w = x >> sh;
            4'd10: begin s = sx >>> sh; r.w = s[31:0]; end
`endif
            default: r.il = 1'b1;
        endcase
        r.z = (r.w == 32'd0);
        r.n = r.w[31];
        return r;
    endfunction

    function automatic vec_t mk(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                input logic [31:0] ew, input logic z, input logic n,
                                input logic c, input logic v, input logic il);
        vec_t t;
        t.op = o; t.a = x; t.b = y;
        t.e.w = ew; t.e.z = z; t.e.n = n; t.e.c = c; t.e.o = v; t.e.il = il;
        return t;
    endfunction

    function automatic logic [31:0] rv();
        case ($urandom_range(0, 7))
            0: return 32'h7FFF_FFFF;
            1: return 32'h8000_0000;
            2: return 32'h0;
            3: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // One clock with scoreboarded handshakes; accepts are stamped with the edge that takes them.
    task automatic cyc(input logic iv, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic ordy);
        sb_t s;
        logic exp_ov;
        @(posedge clk);
        ecnt++;
        #1;
        if (stall_prev) chk("stall_hold", {out_valid, dut_pk()}, {1'b1, snap});
        in_valid = iv; op = o; a = x; b = y; out_ready = ordy;
        #1;
        chk("in_ready", in_ready, !(q.size() == 2 && !ordy));
        if (!in_ready) inr_low = 1'b1;
        exp_ov = 1'b0;
        if (q.size() > 0) exp_ov = (ecnt >= q[0].acc + 1);
        chk("out_valid", out_valid, exp_ov);
        if (out_valid && ordy && q.size() > 0) begin
            chk("result", dut_pk(), pk(q[0].e));
            void'(q.pop_front());
            n_out++;
        end
        if (iv && in_ready) begin
            s.e = ref_alu(o, x, y);
            s.acc = ecnt + 1;
            q.push_back(s);
            n_acc++;
        end
        stall_prev = out_valid && !ordy;
        snap = dut_pk();
    endtask

    initial begin
        logic [3:0] t4op[8];
        int n0, o0, k;

        tbl[0]  = mk(4'h0, 32'd7,         32'hFFFF_FFF9, 32'h0,         1, 0, 1, 0, 0);
        tbl[1]  = mk(4'h0, 32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 0, 1, 0, 1, 0);
        tbl[2]  = mk(4'h1, 32'd0,         32'd1,         32'hFFFF_FFFF, 0, 1, 0, 0, 0);
        tbl[3]  = mk(4'h5, 32'hFFFF_FFFF, 32'd1,         32'd1,         0, 0, 0, 0, 0);
        tbl[4]  = mk(4'h6, 32'hFFFF_FFFF, 32'd1,         32'd0,         1, 0, 0, 0, 0);
        tbl[5]  = mk(4'hF, 32'h1234_5678, 32'd9,         32'd0,         1, 0, 0, 0, 1);
`ifdef PIPE_ALU_SHIFT_EN
        tbl[6]  = mk(4'hA, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 0, 1, 0, 0, 0);
`else
        tbl[6]  = mk(4'hA, 32'h8000_0000, 32'h0000_0024, 32'd0,         1, 0, 0, 0, 1);
`endif
        tbl[7]  = mk(4'h2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0, 1, 0, 0, 0);
        tbl[8]  = mk(4'h3, 32'd0,         32'd0,         32'd0,         1, 0, 0, 0, 0);
        tbl[9]  = mk(4'h4, 32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF, 0, 1, 0, 0, 0);
        tbl[10] = mk(4'h1, 32'd5,         32'd5,         32'd0,         1, 0, 1, 0, 0);
        tbl[11] = mk(4'h1, 32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 0, 0, 1, 1, 0);
        tbl[12] = mk(4'h7, 32'd1,         32'd1,         32'd0,         1, 0, 0, 0, 1);
        tbl[13] = mk(4'h0, 32'hFFFF_FFFF, 32'd1,         32'd0,         1, 0, 1, 0, 0);
        tbl[14] = mk(4'h5, 32'd1,         32'hFFFF_FFFF, 32'd0,         1, 0, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("reset_state", {in_ready, out_valid, dut_pk()}, {1'b1, 1'b0, RSTPK});

        // Directed vectors, one at a time, with latency checks.
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; op = tbl[i].op; a = tbl[i].a; b = tbl[i].b; out_ready = 1'b1;
            #1 chk("tbl_in_ready", in_ready, 1'b1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk("tbl_latency", out_valid, 1'b0);
            @(posedge clk); #1;
            chk($sformatf("tbl%0d", i), {out_valid, dut_pk()}, {1'b1, pk(tbl[i].e)});
        end
        @(posedge clk); #1;
        chk("tbl_drained", out_valid, 1'b0);

        // Eight back-to-back ops with the consumer stalled for cycles 3..6.
        t4op = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hF};
        n0 = n_acc; o0 = n_out; inr_low = 1'b0;
        for (int c = 0; c < 40 && n_acc - n0 < 8; c++) begin
            k = n_acc - n0;
            cyc(1'b1, t4op[k], 32'h100 * k + 32'd3, 32'd7 - k, !(c >= 3 && c <= 6));
        end
        repeat (6) cyc(1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
        chk("stall_in_ready_low", inr_low, 1'b1);
        chk("stall_all_delivered", n_out - o0, 8);

        // Random stream with random backpressure.
        for (int c = 0; c < 500; c++)
            cyc($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), rv(), rv(),
                $urandom_range(0, 3) != 0);
        repeat (8) cyc(1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
        chk("random_drained", q.size(), 0);

        // Reset with both stages full: everything in flight is dropped.
        cyc(1'b1, 4'h0, 32'd1, 32'd2, 1'b0);
        cyc(1'b1, 4'h1, 32'd9, 32'd3, 1'b0);
        cyc(1'b0, 4'h0, 32'd0, 32'd0, 1'b0);
        chk("pre_reset_full", {out_valid, in_ready}, 2'b10);
        #1 rst = 1'b1;
        #1 chk("reset_async", {out_valid, dut_pk()}, {1'b0, RSTPK});
        q.delete();
        stall_prev = 1'b0;
        in_valid = 1'b0;
        #1 rst = 1'b0;
        #1 chk("reset_in_ready", in_ready, 1'b1);
        o0 = n_out;
        cyc(1'b1, 4'h2, 32'h0000_00FF, 32'h0000_000F, 1'b1);
        repeat (6) cyc(1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
        chk("reset_single_out", n_out - o0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
